// File: rtl/axis_packet_steer_if.sv
// Signal bundle for axis_packet_steer: packet input, routing-word input and steered output streams.
// The slave modport is the steering stage's view; master is the surrounding environment.
interface axis_packet_steer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEST_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_packet_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_packet_axis_tkeep;
  logic                  s_packet_axis_tlast;
  logic                  s_packet_axis_tvalid;
  logic                  s_packet_axis_tready;

  logic [DEST_WIDTH-1:0] s_addr_axis_tdata;
  logic                  s_addr_axis_tvalid;
  logic                  s_addr_axis_tready;

  logic [DATA_WIDTH-1:0] m_packet_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_packet_axis_tkeep;
  logic                  m_packet_axis_tlast;
  logic [DEST_WIDTH-1:0] m_packet_axis_tdest;
  logic                  m_packet_axis_tvalid;
  logic                  m_packet_axis_tready;

  modport master (
    output s_packet_axis_tdata, s_packet_axis_tkeep, s_packet_axis_tlast, s_packet_axis_tvalid,
    input  s_packet_axis_tready,
    output s_addr_axis_tdata, s_addr_axis_tvalid,
    input  s_addr_axis_tready,
    input  m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tlast, m_packet_axis_tdest,
    input  m_packet_axis_tvalid,
    output m_packet_axis_tready
  );

  modport slave (
    input  s_packet_axis_tdata, s_packet_axis_tkeep, s_packet_axis_tlast, s_packet_axis_tvalid,
    output s_packet_axis_tready,
    input  s_addr_axis_tdata, s_addr_axis_tvalid,
    output s_addr_axis_tready,
    output m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tlast, m_packet_axis_tdest,
    output m_packet_axis_tvalid,
    input  m_packet_axis_tready
  );
endinterface

// File: rtl/axis_packet_steer.sv
// Pairs each packet with one routing word, forwards it with that word as tdest or drops it,
// through a registered output slice; counts forwarded and dropped packets.
module axis_packet_steer #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int                    DEST_WIDTH  = 32,
  parameter int                    NUM_DEST    = 4,
  parameter logic [DEST_WIDTH-1:0] DROP_DEST   = '1,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_packet_steer_if.slave     bus,
  output logic [COUNT_WIDTH-1:0] fwd_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]            state_q;
  logic [DEST_WIDTH-1:0] dest_q;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q;
  logic [DEST_WIDTH-1:0] m_dest_q;

  logic pkt_ready;
  logic addr_fire;
  logic pkt_fire;
  logic load;
  logic addr_drop;

  assign bus.s_addr_axis_tready   = (state_q == IDLE);
  assign bus.s_packet_axis_tready = pkt_ready;

  assign bus.m_packet_axis_tvalid = m_valid_q;
  assign bus.m_packet_axis_tdata  = m_data_q;
  assign bus.m_packet_axis_tkeep  = m_keep_q;
  assign bus.m_packet_axis_tlast  = m_last_q;
  assign bus.m_packet_axis_tdest  = m_dest_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pkt_ready = 1'b0;
    case (state_q)
      FWD:     pkt_ready = !m_valid_q || bus.m_packet_axis_tready;
      DROP:    pkt_ready = 1'b1;
      default: pkt_ready = 1'b0;
    endcase
  end

  assign addr_fire = bus.s_addr_axis_tvalid && (state_q == IDLE);
  assign pkt_fire  = bus.s_packet_axis_tvalid && pkt_ready;
  assign load      = pkt_fire && (state_q == FWD);
  // The drop code wins even when it is numerically a legal destination.
  assign addr_drop = (bus.s_addr_axis_tdata == DROP_DEST) ||
                     (bus.s_addr_axis_tdata >= DEST_WIDTH'(NUM_DEST));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (addr_fire) begin
          dest_q  <= bus.s_addr_axis_tdata;
          state_q <= addr_drop ? DROP : FWD;
        end
        FWD, DROP: if (pkt_fire && bus.s_packet_axis_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the output data registers are reset too, so m-side fields read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_dest_q  <= '0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= bus.s_packet_axis_tdata;
      m_keep_q  <= bus.s_packet_axis_tkeep;
      m_last_q  <= bus.s_packet_axis_tlast;
      m_dest_q  <= dest_q;
    end else if (bus.m_packet_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Counters advance on the tlast acceptance edge, independent of the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else if (pkt_fire && bus.s_packet_axis_tlast) begin
      if (state_q == FWD)  fwd_count  <= fwd_count + COUNT_WIDTH'(1);
      if (state_q == DROP) drop_count <= drop_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_packet_steer.sv
// Scoreboard bench for axis_packet_steer: drivers push expected beats, a monitor pops and
// compares on every output handshake.
module tb_axis_packet_steer;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int AW = 32;
  localparam int ND = 4;
  localparam int CW = 4;
  localparam logic [AW-1:0] DROP_CODE = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_packet_steer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(AW)) bus ();
  logic [CW-1:0] fwd_count;
  logic [CW-1:0] drop_count;

  axis_packet_steer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(AW),
    .NUM_DEST(ND), .DROP_DEST(DROP_CODE), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [AW-1:0] dest;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int ready_mode = 0;
  bit addr_pending = 1'b0;

  task automatic check(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%s required=%s", name, act, req);
    end
  endtask

  function automatic string fmt_out();
    return $sformatf("v=%0d d=%h k=%h l=%0d t=%0h", bus.m_packet_axis_tvalid, bus.m_packet_axis_tdata,
                     bus.m_packet_axis_tkeep, bus.m_packet_axis_tlast, bus.m_packet_axis_tdest);
  endfunction

  // Downstream ready: always high, 1,0,0,1 pattern, or random.
  initial begin
    int phase = 0;
    bus.m_packet_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       begin bus.m_packet_axis_tready = (phase == 0) || (phase == 3); phase = (phase + 1) % 4; end
        2:       bus.m_packet_axis_tready = 1'($urandom_range(0, 1));
        default: begin bus.m_packet_axis_tready = 1'b1; phase = 0; end
      endcase
    end
  end

  // Monitor: a beat is consumed at the edge following a negedge that sees valid && ready.
  initial begin
    beat_t e;
    beat_t held;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (bus.m_packet_axis_tvalid) begin
        if (stalled)
          check(bus.m_packet_axis_tdata == held.data && bus.m_packet_axis_tkeep == held.keep &&
                bus.m_packet_axis_tlast == held.last && bus.m_packet_axis_tdest == held.dest,
                "stall_stable", fmt_out(),
                $sformatf("d=%h k=%h l=%0d t=%0h", held.data, held.keep, held.last, held.dest));
        if (bus.m_packet_axis_tready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_beat", fmt_out(), "no beat");
          end else begin
            e = sb.pop_front();
            check(bus.m_packet_axis_tdata == e.data && bus.m_packet_axis_tkeep == e.keep &&
                  bus.m_packet_axis_tlast == e.last && bus.m_packet_axis_tdest == e.dest,
                  "out_beat", fmt_out(),
                  $sformatf("d=%h k=%h l=%0d t=%0h", e.data, e.keep, e.last, e.dest));
          end
        end else begin
          stalled = 1'b1;
          held = '{bus.m_packet_axis_tdata, bus.m_packet_axis_tkeep, bus.m_packet_axis_tlast,
                   bus.m_packet_axis_tdest};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic check_counts(input string name);
    check(fwd_count == CW'(exp_fwd) && drop_count == CW'(exp_drop), name,
          $sformatf("fwd=%0d drop=%0d", fwd_count, drop_count),
          $sformatf("fwd=%0d drop=%0d", CW'(exp_fwd), CW'(exp_drop)));
  endtask

  task automatic send_addr(input logic [AW-1:0] a);
    int n = 0;
    bus.s_addr_axis_tdata  = a;
    bus.s_addr_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_addr_axis_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check(1'b0, "addr_timeout", "no ready", "ready");
    @(posedge clk);
    #1;
    bus.s_addr_axis_tvalid = 1'b0;
  endtask

  // Model: a packet is dropped iff its word is the drop code or not a legal destination.
  // stop_at >= 0 presents that beat and returns without waiting for it.
  task automatic send_pkt(input logic [AW-1:0] a, input int len, input bit fixed,
                          input int gap_max, input int stop_at);
    bit drop = (a == DROP_CODE) || (a >= AW'(ND));
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      bit last = (i == len - 1);
      bit first = 1'b1;
      int n = 0;
      d = fixed ? DW'((i + 1) * 'h11) : {$urandom, $urandom};
      k = fixed ? '1 : (($urandom_range(0, 3) == 0) ? '0 : KW'($urandom));
      repeat ($urandom_range(0, gap_max)) begin
        bus.s_packet_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.s_packet_axis_tdata  = d;
      bus.s_packet_axis_tkeep  = k;
      bus.s_packet_axis_tlast  = last;
      bus.s_packet_axis_tvalid = 1'b1;
      if (i == stop_at) return;
      forever begin
        @(negedge clk);
        if (addr_pending)
          check(!bus.s_addr_axis_tready, "addr_blocked", $sformatf("%0d", bus.s_addr_axis_tready), "0");
        if (drop && first)
          check(bus.s_packet_axis_tready, "drop_tready", $sformatf("%0d", bus.s_packet_axis_tready), "1");
        first = 1'b0;
        if (bus.s_packet_axis_tready) break;
        n++;
        if (n > 200) begin
          check(1'b0, "beat_timeout", "no ready", "ready");
          break;
        end
      end
      if (!drop) sb.push_back('{d, k, last, a});
      if (last) begin
        if (drop) exp_drop++;
        else exp_fwd++;
      end
      @(posedge clk);
      #1;
      if (!drop)
        check(bus.m_packet_axis_tvalid && bus.m_packet_axis_tdata == d && bus.m_packet_axis_tdest == a,
              "latency", fmt_out(), $sformatf("v=1 d=%h t=%0h", d, a));
      if (last) check_counts("counters");
    end
    bus.s_packet_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(sb.size() == 0, "drain", $sformatf("%0d left", sb.size()), "0 left");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    exp_fwd = 0;
    exp_drop = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.s_packet_axis_tdata  = '0;
    bus.s_packet_axis_tkeep  = '0;
    bus.s_packet_axis_tlast  = 1'b0;
    bus.s_packet_axis_tvalid = 1'b0;
    bus.s_addr_axis_tdata    = '0;
    bus.s_addr_axis_tvalid   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(!bus.m_packet_axis_tvalid && bus.m_packet_axis_tdata == '0 && bus.m_packet_axis_tkeep == '0 &&
          !bus.m_packet_axis_tlast && bus.m_packet_axis_tdest == '0, "reset_out", fmt_out(), "all 0");
    check_counts("reset_counters");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(bus.s_addr_axis_tready && !bus.s_packet_axis_tready, "reset_ready",
          $sformatf("addr=%0d pkt=%0d", bus.s_addr_axis_tready, bus.s_packet_axis_tready), "addr=1 pkt=0");

    // Basic forward.
    send_addr(2);
    send_pkt(2, 4, 1'b1, 0, -1);
    drain();

    // Drop cases back to back.
    send_addr(DROP_CODE);
    send_pkt(DROP_CODE, 3, 1'b0, 0, -1);
    send_addr(AW'(ND));
    send_pkt(AW'(ND), 2, 1'b0, 0, -1);
    send_addr(1);
    send_pkt(1, 1, 1'b0, 0, -1);
    drain();
    check(fwd_count == 4'd2 && drop_count == 4'd2, "drop_totals",
          $sformatf("fwd=%0d drop=%0d", fwd_count, drop_count), "fwd=2 drop=2");

    // Backpressure.
    ready_mode = 1;
    send_addr(0);
    send_pkt(0, 8, 1'b0, 0, -1);
    drain();
    ready_mode = 0;

    // Packet beats before any address are held off.
    bus.s_packet_axis_tdata  = 'hdead;
    bus.s_packet_axis_tlast  = 1'b0;
    bus.s_packet_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check(!bus.s_packet_axis_tready, "pkt_before_addr", $sformatf("%0d", bus.s_packet_axis_tready), "0");
    end
    @(posedge clk);
    #1;
    send_addr(1);
    send_pkt(1, 3, 1'b0, 0, -1);

    // Second address held until the cycle after the first packet's tlast.
    send_addr(0);
    bus.s_addr_axis_tdata  = 2;
    bus.s_addr_axis_tvalid = 1'b1;
    addr_pending = 1'b1;
    send_pkt(0, 4, 1'b0, 0, -1);
    addr_pending = 1'b0;
    @(negedge clk);
    check(bus.s_addr_axis_tready, "addr_after_tlast", $sformatf("%0d", bus.s_addr_axis_tready), "1");
    @(posedge clk);
    #1;
    bus.s_addr_axis_tvalid = 1'b0;
    send_pkt(2, 2, 1'b0, 0, -1);
    drain();

    // Async reset during beat 3 of 6.
    send_addr(1);
    send_pkt(1, 6, 1'b0, 0, 2);
    rst_n = 1'b0;
    sb.delete();
    exp_fwd = 0;
    exp_drop = 0;
    #1;
    check(!bus.m_packet_axis_tvalid && bus.m_packet_axis_tdata == '0 && bus.m_packet_axis_tdest == '0 &&
          !bus.m_packet_axis_tlast && bus.m_packet_axis_tkeep == '0, "midreset_out", fmt_out(), "all 0");
    check_counts("midreset_counters");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check(!bus.s_packet_axis_tready, "leftover_blocked", $sformatf("%0d", bus.s_packet_axis_tready), "0");
    end
    @(posedge clk);
    #1;
    bus.s_packet_axis_tvalid = 1'b0;
    send_addr(3);
    send_pkt(3, 2, 1'b0, 0, -1);
    drain();

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int p = 0; p < 17; p++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, ND - 1));
      send_addr(a);
      send_pkt(a, 1, 1'b0, 0, -1);
    end
    drain();
    check(fwd_count == 4'd1, "fwd_wrap", $sformatf("%0d", fwd_count), "1");

    // Random traffic with random downstream ready.
    ready_mode = 2;
    for (int p = 0; p < 30; p++) begin
      logic [AW-1:0] a;
      int r = $urandom_range(0, 9);
      if (r < 6)       a = AW'(r % ND);
      else if (r == 6) a = AW'(ND);
      else if (r == 7) a = DROP_CODE;
      else if (r == 8) a = $urandom;
      else             a = AW'(ND - 1);
      send_addr(a);
      send_pkt(a, $urandom_range(1, 5), 1'b0, 2, -1);
    end
    drain();
    ready_mode = 0;
    check_counts("final_counters");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
